led_frame_writer: RTL and testbench
===================================

Name: led_frame_writer

Overview:
- Producer side of the LED panel frame memory: accepts a raster-ordered 24-bit RGB pixel stream and writes it into the double-buffered bit-plane BRAM that the panel driver scans out.
- Each pixel is split into bit planes and packed into the 6-bit {R0,G0,B0,R1,G1,B1} word format: top half of the panel in bits 5:3, bottom half in bits 2:0.
- Always writes the buffer not currently displayed, and reports frame completion so software or the driver can swap buffers.

Parameters:
- N_ROWS_MAX, 64, max panel rows (full height, top+bottom halves).
- N_COLS_MAX, 256, max chained columns.
- BITDEPTH_MAX, 8, bits per colour channel in the input and max bit planes.
- CTRL_REG_WIDTH, 32, width of ctrl inputs.
- MEM_W_ADDR_WIDTH, $clog2(N_ROWS_MAX*N_COLS_MAX)-1, word address width (half-frame).
- MEM_W_DATA_WIDTH, 6, memory word width.

Ports:
- clk  in  1  global clock.
- ctrl_rst  in  1  asynchronous, active-high reset.
- ctrl_en  in  1  enable; low forces IDLE.
- ctrl_n_rows  in  CTRL_REG_WIDTH  active rows (even, 2..N_ROWS_MAX).
- ctrl_n_cols  in  CTRL_REG_WIDTH  active cols (1..N_COLS_MAX).
- ctrl_bitdepth  in  CTRL_REG_WIDTH  bit planes to write.
- disp_buffer  in  1  buffer currently being displayed.
- s_pixel_valid  in  1  pixel valid.
- s_pixel_ready  out  1  pixel accepted when valid&ready.
- s_pixel_sof  in  1  marks first pixel of a frame (row 0, col 0).
- s_pixel_data  in  3*BITDEPTH_MAX  {R,G,B}, R in MSBs.
- mem_clk  out  1  = clk.
- mem_we  out  1  write strobe.
- mem_buffer  out  1  buffer being written.
- mem_addr  out  MEM_W_ADDR_WIDTH  word address.
- mem_bit  out  $clog2(BITDEPTH_MAX)  bit-plane index.
- mem_dout  out  6  write data.
- mem_wmask  out  6  per-bit write enable.
- frame_done  out  1  one-cycle pulse after the last write of a complete frame.
- frame_abort  out  1  one-cycle pulse when SOF arrives mid-frame.

Behaviour:
- Reset values: s_pixel_ready=0, mem_we=0, mem_dout=0, mem_wmask=0, mem_addr=0, mem_bit=0, mem_buffer=0, frame_done=0, frame_abort=0; state=IDLE.
- States:
  - IDLE: ready=1. Pixels without SOF are consumed and dropped. On valid&sof: latch n_rows, n_cols and bitdepth; clamp bitdepth 0->1 and >BITDEPTH_MAX->BITDEPTH_MAX. Set wr_buffer=~disp_buffer, row=0, col=0. Capture the pixel and go to WRITE.
  - ACCEPT: ready=1. On valid: capture pixel, go to WRITE. If sof is also set: pulse frame_abort, reset row/col to 0, relatch config and wr_buffer, then write that pixel.
  - WRITE: ready=0. One write per cycle for planes b=0..bitdepth-1, so the pixel accepted at cycle T is written at T+1..T+bitdepth.
    - mem_bit=b.
    - Plane b takes colour bit (BITDEPTH_MAX-bitdepth+b) of each channel.
    - After the last plane, advance col/row. If the last pixel of the frame (row=n_rows-1, col=n_cols-1) was just written, pulse frame_done on the next cycle and go to IDLE; otherwise go to ACCEPT.
- Sustained throughput: 1 pixel per bitdepth+1 cycles.
- Address and mask (half = n_rows/2):
  - Row < half: addr = row*n_cols+col, wmask=6'b111000.
  - Else: addr = (row-half)*n_cols+col, wmask=6'b000111.
  - mem_dout = {r,g,b,r,g,b} for the plane bit. Only masked bits are significant.
- Counters: col wraps at n_cols-1 and increments row. Row never exceeds n_rows-1.
- Write bus: mem_buffer=wr_buffer for the whole frame. disp_buffer changes mid-frame are ignored until the next SOF.
- ctrl_en low at any time: next cycle state=IDLE, ready=0, mem_we=0, no frame_done. The partial frame is abandoned.
- ctrl_rst mid-WRITE: immediate return to reset values. The partial pixel is not completed.

Optional Feature:
- GAMMA_CORRECT_EN.
- Defined: each channel is replaced by (c*c)>>BITDEPTH_MAX before plane extraction. This adds one pipeline cycle, so the first write is at T+2 and throughput becomes bitdepth+2 cycles/pixel.
- Undefined: channels are written unmodified, with timing as above.

Test Plan:
- n_rows=4, n_cols=2, bitdepth=8, disp_buffer=0; stream 8 pixels with SOF on the first -> 64 writes, all with mem_buffer=1. Rows 0–1 use wmask 111000 at addr 0..3; rows 2–3 use wmask 000111 at addr 0..3. frame_done pulses once, one cycle after the last write.
- Single pixel {R=8'hA5,G=8'h00,B=8'hFF}, bitdepth=8 -> planes 0..7 carry R bits 1,0,1,0,0,1,0,1 (A5 LSB first), G=0 and B=1 on every plane. ready is low for exactly 8 cycles.
- bitdepth=4, pixel R=8'hF0 -> 4 writes, mem_bit 0..3, R=1 on all of them (color bits 4..7).
- SOF asserted on the 3rd pixel of a frame -> frame_abort pulses, that pixel is written to addr 0, and no frame_done occurs for the aborted frame.
- ctrl_rst asserted asynchronously mid-WRITE -> mem_we=0 and ready=0 without waiting for a clock. After release, non-SOF pixels are dropped until an SOF arrives.
- ctrl_bitdepth=0 and ctrl_bitdepth=12 -> 1 write and 8 writes per pixel respectively.

Source files
------------

// File: rtl/led_frame_writer.sv
// led_frame_writer: splits a raster RGB pixel stream into bit planes and writes them to the back buffer.
// Latency: first plane write one cycle after acceptance (two with GAMMA_CORRECT_EN), then one plane per cycle.
// Backpressure: s_pixel_ready is low while a pixel's planes are being written; one pixel per bitdepth+1 cycles.
//
// Ports:
//   clk, ctrl_rst (async, active-high), ctrl_en (low forces IDLE and drops the partial frame)
//   ctrl_n_rows / ctrl_n_cols / ctrl_bitdepth : frame geometry and plane count, latched on SOF
//   disp_buffer  : buffer currently displayed; the other one is written
//   s_pixel_*    : valid/ready pixel stream, {R,G,B} with R in the MSBs, sof on pixel (0,0)
//   mem_*        : bit-plane BRAM write port, {R0,G0,B0,R1,G1,B1} words, top half in bits 5:3
//   frame_done   : pulse the cycle after the last write of a complete frame
//   frame_abort  : pulse when SOF arrives in the middle of a frame
//
// Optional build macro GAMMA_CORRECT_EN: each channel becomes (c*c)>>BITDEPTH_MAX before plane
// extraction, costing one extra pipeline cycle per pixel.

module led_frame_writer #(
    parameter int N_ROWS_MAX       = 64,
    parameter int N_COLS_MAX       = 256,
    parameter int BITDEPTH_MAX     = 8,
    parameter int CTRL_REG_WIDTH   = 32,
    parameter int MEM_W_ADDR_WIDTH = $clog2(N_ROWS_MAX*N_COLS_MAX)-1,
    parameter int MEM_W_DATA_WIDTH = 6
) (
    input  logic                            clk,
    input  logic                            ctrl_rst,
    input  logic                            ctrl_en,
    input  logic [CTRL_REG_WIDTH-1:0]       ctrl_n_rows,
    input  logic [CTRL_REG_WIDTH-1:0]       ctrl_n_cols,
    input  logic [CTRL_REG_WIDTH-1:0]       ctrl_bitdepth,
    input  logic                            disp_buffer,
    input  logic                            s_pixel_valid,
    output logic                            s_pixel_ready,
    input  logic                            s_pixel_sof,
    input  logic [3*BITDEPTH_MAX-1:0]       s_pixel_data,
    output logic                            mem_clk,
    output logic                            mem_we,
    output logic                            mem_buffer,
    output logic [MEM_W_ADDR_WIDTH-1:0]     mem_addr,
    output logic [$clog2(BITDEPTH_MAX)-1:0] mem_bit,
    output logic [MEM_W_DATA_WIDTH-1:0]     mem_dout,
    output logic [MEM_W_DATA_WIDTH-1:0]     mem_wmask,
    output logic                            frame_done,
    output logic                            frame_abort
);

    localparam int ROW_W = $clog2(N_ROWS_MAX + 1);
    localparam int COL_W = $clog2(N_COLS_MAX + 1);
    localparam int BD_W  = $clog2(BITDEPTH_MAX + 1);
    localparam int BIT_W = $clog2(BITDEPTH_MAX);
    localparam int PIX_W = 3 * BITDEPTH_MAX;

    localparam logic [MEM_W_DATA_WIDTH-1:0] MASK_TOP = MEM_W_DATA_WIDTH'(6'b111000);
    localparam logic [MEM_W_DATA_WIDTH-1:0] MASK_BOT = MEM_W_DATA_WIDTH'(6'b000111);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
`ifdef GAMMA_CORRECT_EN
    localparam logic [1:0] ST_GAMMA  = 2'd3;
`endif

    logic [1:0]                  state;
    logic [ROW_W-1:0]            n_rows_q;
    logic [COL_W-1:0]            n_cols_q;
    logic [BD_W-1:0]             bd_q;
    // Position of the pixel currently held (or next to be accepted).
    logic [ROW_W-1:0]            row_q;
    logic [COL_W-1:0]            col_q;
    // Running half-frame word address; restarts at 0 when the bottom half begins.
    logic [MEM_W_ADDR_WIDTH-1:0] addr_q;
    logic                        bottom_q;
    logic [PIX_W-1:0]            pix_q;

    logic [ROW_W-1:0]            cfg_rows;
    logic [COL_W-1:0]            cfg_cols;
    logic [BD_W-1:0]             cfg_bd;
    logic                        accept;
    logic                        take;
    logic                        last_plane;
    logic                        last_col;
    logic                        last_row;
    logic                        half_row_end;
`ifndef GAMMA_CORRECT_EN
    logic [BD_W-1:0]             bd_eff;
`endif

    assign mem_clk = clk;

    // Extract plane b: the bitdepth most significant bits of each channel are used, plane 0 = least
    // significant of those.
    function automatic logic [MEM_W_DATA_WIDTH-1:0] plane_word(
        input logic [PIX_W-1:0] px,
        input logic [BD_W-1:0]  bd,
        input logic [BIT_W-1:0] b
    );
        logic [BITDEPTH_MAX-1:0] cr;
        logic [BITDEPTH_MAX-1:0] cg;
        logic [BITDEPTH_MAX-1:0] cb;
        logic [BIT_W-1:0]        sel;
        cr  = px[3*BITDEPTH_MAX-1:2*BITDEPTH_MAX];
        cg  = px[2*BITDEPTH_MAX-1:BITDEPTH_MAX];
        cb  = px[BITDEPTH_MAX-1:0];
        sel = BIT_W'(BITDEPTH_MAX - int'(bd) + int'(b));
        return MEM_W_DATA_WIDTH'({cr[sel], cg[sel], cb[sel], cr[sel], cg[sel], cb[sel]});
    endfunction

`ifdef GAMMA_CORRECT_EN
    function automatic logic [PIX_W-1:0] gamma(input logic [PIX_W-1:0] px);
        logic [PIX_W-1:0]          o;
        logic [BITDEPTH_MAX-1:0]   c;
        logic [2*BITDEPTH_MAX-1:0] sq;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            c  = px[ch*BITDEPTH_MAX +: BITDEPTH_MAX];
            sq = {{BITDEPTH_MAX{1'b0}}, c} * {{BITDEPTH_MAX{1'b0}}, c};
            o[ch*BITDEPTH_MAX +: BITDEPTH_MAX] = sq[2*BITDEPTH_MAX-1:BITDEPTH_MAX];
        end
        return o;
    endfunction
`endif

    always_comb begin
        // Out-of-range geometry is clamped so a bad register value cannot overrun the buffer.
        cfg_rows = (ctrl_n_rows > CTRL_REG_WIDTH'(N_ROWS_MAX)) ? ROW_W'(N_ROWS_MAX)
                                                               : ctrl_n_rows[ROW_W-1:0];
        cfg_cols = (ctrl_n_cols > CTRL_REG_WIDTH'(N_COLS_MAX)) ? COL_W'(N_COLS_MAX)
                                                               : ctrl_n_cols[COL_W-1:0];
        if (ctrl_bitdepth == '0)
            cfg_bd = BD_W'(1);
        else if (ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX))
            cfg_bd = BD_W'(BITDEPTH_MAX);
        else
            cfg_bd = ctrl_bitdepth[BD_W-1:0];

        accept       = s_pixel_valid && s_pixel_ready;
        // In IDLE only an SOF pixel starts a frame; anything else is consumed and dropped.
        take         = accept && (s_pixel_sof || (state == ST_ACCEPT));
        last_plane   = (BD_W'(mem_bit) + BD_W'(1)) == bd_q;
        last_col     = col_q == (n_cols_q - COL_W'(1));
        last_row     = row_q == (n_rows_q - ROW_W'(1));
        half_row_end = row_q == ((n_rows_q >> 1) - ROW_W'(1));
`ifndef GAMMA_CORRECT_EN
        bd_eff       = s_pixel_sof ? cfg_bd : bd_q;
`endif
    end

    always_ff @(posedge clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            state         <= ST_IDLE;
            s_pixel_ready <= 1'b0;
            mem_we        <= 1'b0;
            mem_buffer    <= 1'b0;
            mem_addr      <= '0;
            mem_bit       <= '0;
            mem_dout      <= '0;
            mem_wmask     <= '0;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
            n_rows_q      <= '0;
            n_cols_q      <= '0;
            bd_q          <= '0;
            row_q         <= '0;
            col_q         <= '0;
            addr_q        <= '0;
            bottom_q      <= 1'b0;
            pix_q         <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (!ctrl_en) begin
                state         <= ST_IDLE;
                s_pixel_ready <= 1'b0;
                mem_we        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_ACCEPT: begin
                        s_pixel_ready <= 1'b1;
                        mem_we        <= 1'b0;
                        if (take) begin
                            if (s_pixel_sof) begin
                                n_rows_q    <= cfg_rows;
                                n_cols_q    <= cfg_cols;
                                bd_q        <= cfg_bd;
                                mem_buffer  <= ~disp_buffer;
                                row_q       <= '0;
                                col_q       <= '0;
                                addr_q      <= '0;
                                bottom_q    <= 1'b0;
                                frame_abort <= (state == ST_ACCEPT);
                            end
                            pix_q         <= s_pixel_data;
                            s_pixel_ready <= 1'b0;
`ifdef GAMMA_CORRECT_EN
                            state         <= ST_GAMMA;
`else
                            state         <= ST_WRITE;
                            mem_we        <= 1'b1;
                            mem_bit       <= '0;
                            mem_dout      <= plane_word(s_pixel_data, bd_eff, '0);
                            // Counters are only cleared at this edge, so SOF selects position 0 here.
                            mem_addr      <= s_pixel_sof ? '0 : addr_q;
                            mem_wmask     <= (s_pixel_sof || !bottom_q) ? MASK_TOP : MASK_BOT;
`endif
                        end
                    end
`ifdef GAMMA_CORRECT_EN
                    ST_GAMMA: begin
                        pix_q     <= gamma(pix_q);
                        state     <= ST_WRITE;
                        mem_we    <= 1'b1;
                        mem_bit   <= '0;
                        mem_dout  <= plane_word(gamma(pix_q), bd_q, '0);
                        mem_addr  <= addr_q;
                        mem_wmask <= bottom_q ? MASK_BOT : MASK_TOP;
                    end
`endif
                    ST_WRITE: begin
                        if (last_plane) begin
                            mem_we        <= 1'b0;
                            s_pixel_ready <= 1'b1;
                            if (last_row && last_col) begin
                                frame_done <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                state <= ST_ACCEPT;
                                if (last_col) begin
                                    col_q <= '0;
                                    row_q <= row_q + ROW_W'(1);
                                    if (half_row_end) begin
                                        addr_q   <= '0;
                                        bottom_q <= 1'b1;
                                    end else begin
                                        addr_q <= addr_q + MEM_W_ADDR_WIDTH'(1);
                                    end
                                end else begin
                                    col_q  <= col_q + COL_W'(1);
                                    addr_q <= addr_q + MEM_W_ADDR_WIDTH'(1);
                                end
                            end
                        end else begin
                            mem_bit  <= mem_bit + BIT_W'(1);
                            mem_dout <= plane_word(pix_q, bd_q, mem_bit + BIT_W'(1));
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_frame_writer.sv
// tb_led_frame_writer: randomized stream into led_frame_writer, scoreboard against a raster model.
// Latency: n/a (testbench).
// Backpressure: driver holds each pixel until s_pixel_ready is seen.

module tb_led_frame_writer;

    localparam int BDM     = 8;
    localparam int K_WRITE = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;
`ifdef GAMMA_CORRECT_EN
    localparam int GAM = 1;
`else
    localparam int GAM = 0;
`endif

    typedef struct {
        int          kind;
        logic [31:0] word;
    } exp_t;

    exp_t expq[$];

    logic        clk = 1'b0;
    logic        ctrl_rst = 1'b1;
    logic        ctrl_en = 1'b0;
    logic [31:0] ctrl_n_rows = 32'd2;
    logic [31:0] ctrl_n_cols = 32'd1;
    logic [31:0] ctrl_bitdepth = 32'd8;
    logic        disp_buffer = 1'b0;
    logic        s_pixel_valid = 1'b0;
    logic        s_pixel_ready;
    logic        s_pixel_sof = 1'b0;
    logic [23:0] s_pixel_data = '0;
    logic        mem_clk;
    logic        mem_we;
    logic        mem_buffer;
    logic [12:0] mem_addr;
    logic [2:0]  mem_bit;
    logic [5:0]  mem_dout;
    logic [5:0]  mem_wmask;
    logic        frame_done;
    logic        frame_abort;

    led_frame_writer dut (
        .clk           (clk),
        .ctrl_rst      (ctrl_rst),
        .ctrl_en       (ctrl_en),
        .ctrl_n_rows   (ctrl_n_rows),
        .ctrl_n_cols   (ctrl_n_cols),
        .ctrl_bitdepth (ctrl_bitdepth),
        .disp_buffer   (disp_buffer),
        .s_pixel_valid (s_pixel_valid),
        .s_pixel_ready (s_pixel_ready),
        .s_pixel_sof   (s_pixel_sof),
        .s_pixel_data  (s_pixel_data),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_buffer    (mem_buffer),
        .mem_addr      (mem_addr),
        .mem_bit       (mem_bit),
        .mem_dout      (mem_dout),
        .mem_wmask     (mem_wmask),
        .frame_done    (frame_done),
        .frame_abort   (frame_abort)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int last_we_cyc = -100;

    // Reference model state: one frame in flight, raster position as a linear pixel index.
    bit m_in_frame = 1'b0;
    int m_k, m_rows, m_cols, m_bd;
    bit m_buf;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [31:0] pack(input bit b, input int addr, input int bitn,
                                         input logic [5:0] mask, input logic [5:0] dout);
        logic [12:0] a;
        logic [2:0]  bn;
        a  = addr[12:0];
        bn = bitn[2:0];
        return {3'b000, b, a, bn, mask, dout & mask};
    endfunction

    function automatic int head_kind();
        return (expq.size() > 0) ? expq[0].kind : -1;
    endfunction

    // Returns the number of cycles ready should stay low after this pixel is accepted.
    function automatic int model_accept(input logic [23:0] d, input bit sof);
        int row, col, half, addr, bdc, idx;
        logic [7:0] ch[3];
        logic [5:0] mask, w;
        exp_t e;
        if (sof) begin
            if (m_in_frame) begin
                e.kind = K_ABORT; e.word = '0; expq.push_back(e);
            end
            m_in_frame = 1'b1;
            m_k    = 0;
            m_rows = int'(ctrl_n_rows);
            m_cols = int'(ctrl_n_cols);
            bdc    = int'(ctrl_bitdepth);
            m_bd   = (bdc == 0) ? 1 : ((bdc > BDM) ? BDM : bdc);
            m_buf  = ~disp_buffer;
        end
        if (!m_in_frame) return 0;
        row  = m_k / m_cols;
        col  = m_k % m_cols;
        half = m_rows / 2;
        if (row < half) begin
            addr = row * m_cols + col;          mask = 6'b111000;
        end else begin
            addr = (row - half) * m_cols + col; mask = 6'b000111;
        end
        ch[0] = d[23:16]; ch[1] = d[15:8]; ch[2] = d[7:0];
`ifdef GAMMA_CORRECT_EN
        for (int c = 0; c < 3; c++) ch[c] = 8'((int'(ch[c]) * int'(ch[c])) >> BDM);
`endif
        for (int b = 0; b < m_bd; b++) begin
            idx = BDM - m_bd + b;
            w = {ch[0][idx], ch[1][idx], ch[2][idx], ch[0][idx], ch[1][idx], ch[2][idx]};
            e.kind = K_WRITE;
            e.word = pack(m_buf, addr, b, mask, w);
            expq.push_back(e);
        end
        m_k++;
        if (m_k == m_rows * m_cols) begin
            m_in_frame = 1'b0;
            e.kind = K_DONE; e.word = '0; expq.push_back(e);
        end
        return m_bd + GAM;
    endfunction

    // Monitor: everything the DUT presents is popped and compared in order.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (frame_abort) begin
            chk("abort_kind", head_kind(), K_ABORT);
            if (expq.size() > 0) void'(expq.pop_front());
        end
        if (mem_we) begin
            chk("write_kind", head_kind(), K_WRITE);
            if (head_kind() == K_WRITE)
                chk("write_buf_addr_bit_mask_data",
                    pack(mem_buffer, int'(mem_addr), int'(mem_bit), mem_wmask, mem_dout),
                    expq[0].word);
            if (expq.size() > 0) void'(expq.pop_front());
            last_we_cyc = cyc;
        end
        if (frame_done) begin
            chk("done_kind", head_kind(), K_DONE);
            chk("done_latency", cyc - last_we_cyc, 1);
            if (expq.size() > 0) void'(expq.pop_front());
        end
    end

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic [23:0] d, input bit sof, input bit measure);
        int n = 0;
        int exp_low;
        s_pixel_valid = 1'b1; s_pixel_sof = sof; s_pixel_data = d;
        while (!s_pixel_ready && n < 100) begin @(negedge clk); n++; end
        chk("ready_seen", s_pixel_ready, 1);
        if (!s_pixel_ready) begin
            s_pixel_valid = 1'b0; s_pixel_sof = 1'b0;
            return;
        end
        exp_low = model_accept(d, sof);
        @(negedge clk);
        s_pixel_valid = 1'b0; s_pixel_sof = 1'b0;
        if (measure) begin
            n = 0;
            while (!s_pixel_ready && n < 100) begin @(negedge clk); n++; end
            chk("ready_low_cycles", n, exp_low);
        end
    endtask

    task automatic cfg(input int r, input int c, input int b);
        ctrl_n_rows = 32'(r); ctrl_n_cols = 32'(c); ctrl_bitdepth = 32'(b);
    endtask

    task automatic frame(input int npix);
        for (int i = 0; i < npix; i++) send(24'($urandom), i == 0, 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expq.size() > 0 && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk(name, expq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        ctrl_rst = 1'b1; ctrl_en = 1'b1;
        #3;
        chk("rst_ready", s_pixel_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_dout", mem_dout, 0);
        chk("rst_wmask", mem_wmask, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_bit", mem_bit, 0);
        chk("rst_buffer", mem_buffer, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_abort", frame_abort, 0);
        @(negedge clk); @(negedge clk);
        ctrl_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", s_pixel_ready, 1);
        @(posedge clk); #1;
        chk("mem_clk_follows_clk", mem_clk, clk);
        @(negedge clk);

        // 4x2 frame, 8 planes, written into buffer 1.
        disp_buffer = 1'b0; cfg(4, 2, 8);
        frame(8);
        drain("drain_frame_4x2");

        // Single pixel A5/00/FF.
        cfg(2, 1, 8);
        send(24'hA500FF, 1'b1, 1'b1);
        drain("drain_a5");

        // Four planes from the upper nibble.
        cfg(2, 1, 4);
        send({8'hF0, 16'($urandom)}, 1'b1, 1'b1);
        drain("drain_bd4");

        // SOF on the third pixel restarts the frame.
        disp_buffer = 1'b1; cfg(4, 4, 3);
        send(24'($urandom), 1'b1, 1'b1);
        send(24'($urandom), 1'b0, 1'b1);
        frame(16);
        drain("drain_abort");

        // Bit depth clamps.
        cfg(2, 2, 0);  frame(4); drain("drain_bd0");
        cfg(2, 2, 12); frame(4); drain("drain_bd12");

        // Asynchronous reset in the middle of a pixel.
        cfg(2, 2, 8);
        send(24'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        #2 ctrl_rst = 1'b1;
        #1;
        chk("async_rst_we", mem_we, 0);
        chk("async_rst_ready", s_pixel_ready, 0);
        chk("async_rst_bit", mem_bit, 0);
        expq.delete(); m_in_frame = 1'b0;
        @(negedge clk); @(negedge clk);
        ctrl_rst = 1'b0;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, 1'b1);
        frame(4);
        drain("drain_after_rst");

        // Enable dropped mid-frame abandons the frame.
        cfg(4, 2, 5);
        send(24'($urandom), 1'b1, 1'b1);
        send(24'($urandom), 1'b0, 1'b0);
        #1 ctrl_en = 1'b0;
        @(negedge clk);
        chk("en_low_we", mem_we, 0);
        chk("en_low_ready", s_pixel_ready, 0);
        expq.delete(); m_in_frame = 1'b0;
        repeat (6) @(negedge clk);
        ctrl_en = 1'b1;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 2; i++) send(24'($urandom), 1'b0, 1'b1);
        frame(8);
        drain("drain_after_en");

        // Random geometries; display buffer flips mid-frame and must be ignored.
        for (int t = 0; t < 6; t++) begin
            int r, c, np;
            r = 2 * $urandom_range(1, 4);
            c = $urandom_range(1, 5);
            cfg(r, c, $urandom_range(0, 10));
            disp_buffer = 1'($urandom);
            np = r * c;
            for (int i = 0; i < np; i++) begin
                send(24'($urandom), i == 0, 1'b1);
                if (i == 0) disp_buffer = ~disp_buffer;
            end
            drain("drain_random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
